// File: rtl/ysyx_25040109_lsu.sv
// Load/store unit: one core request at a time becomes one single-beat AXI read or write.
// Latency: 3 cycles from acceptance to resp_valid with an immediately ready slave (1 cycle for a rejected misaligned access).
// Backpressure: req_ready only in IDLE; AXI valids are held until handshake; resp_valid is a one-cycle pulse with no backpressure.
// Optional feature: define YSYX_25040109_LSU_MISALIGN_CHECK_EN to reject misaligned half/word accesses without bus traffic.
module ysyx_25040109_lsu #(
  parameter logic [3:0] AXI_ID = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  // core request
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  // core response
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // AXI read
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  output logic [3:0]  arid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  input  logic [3:0]  rid,
  input  logic        rlast,
  // AXI write
  output logic [31:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q, xresp_q;
  logic [3:0]  rid_q;
  logic        sext_q, wen_q, mis_q;
  logic        aw_done, w_done;
  logic        req_fire, aw_fire, w_fire, r_fire, b_fire, misaligned;
  logic        txn_err;
  logic [31:0] shifted, load_val;
  logic [3:0]  strb_base;

  // Transfers are single-beat, so the last-beat marker carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast;

`ifdef YSYX_25040109_LSU_MISALIGN_CHECK_EN
  // Half must sit on an even address, word (and size 3) on a multiple of four.
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign req_fire = req_valid && req_ready;
  assign aw_fire  = awvalid && awready;
  assign w_fire   = wvalid && wready;
  assign r_fire   = rvalid && rready;
  assign b_fire   = bvalid && bready;

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and the handshake-level outputs that depend only on state.
  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_fire) begin
          if (misaligned)   state_nxt = RESP;
          else if (req_wen) state_nxt = AW_W;
          else              state_nxt = AR;
        end
      end
      AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_nxt = RESP;
      end
      AW_W: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch on acceptance, response capture on R/B handshakes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      wen_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      xresp_q <= '0;
      rid_q   <= '0;
    end else begin
      if (req_fire) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        sext_q  <= req_sext;
        wen_q   <= req_wen;
        mis_q   <= misaligned;
      end
      if (r_fire) begin
        rdata_q <= rdata;
        xresp_q <= rresp;
        rid_q   <= rid;
      end
      if (b_fire) xresp_q <= bresp;
    end
  end

  // AW and W retire independently; the flags only live while in AW_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if ((state == AW_W) && (state_nxt == AW_W)) begin
      aw_done <= aw_done || aw_fire;
      w_done  <= w_done || w_fire;
    end else begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end
  end

  assign araddr  = addr_q;
  assign arid    = AXI_ID;
  assign awaddr  = addr_q;
  assign wdata   = wdata_q;

  // Strobe mask is lane-shifted by the byte offset; lanes past bit 3 fall off.
  always_comb begin
    case (size_q)
      2'd0:    strb_base = 4'b0001;
      2'd1:    strb_base = 4'b0011;
      default: strb_base = 4'b1111;
    endcase
    wstrb = strb_base << addr_q[1:0];
  end

  // Load alignment/extension and the gated response payload.
  always_comb begin
    shifted = rdata_q >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_val = {{24{sext_q && shifted[7]}},  shifted[7:0]};
      2'd1:    load_val = {{16{sext_q && shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
    txn_err    = mis_q || (xresp_q != 2'b00) || (!wen_q && (rid_q != AXI_ID));
    resp_err   = (state == RESP) && txn_err;
    resp_rdata = ((state == RESP) && !txn_err && !wen_q) ? load_val : 32'h0;
  end

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Testbench for ysyx_25040109_lsu: table vectors, directed reset sequences, random traffic vs a reference model.
// Latency: a responsive AXI slave is modelled per transaction with programmable ready/valid delays.
// Backpressure: slave delays stall AR/AW/W/B; the bench checks valid/payload stability and a single response pulse.
module tb_ysyx_25040109_lsu;

  localparam logic [3:0] ID = 4'h1;
  localparam int CYC_MAX = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_wen = 1'b0, req_sext = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic [3:0]  arid, wstrb;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [3:0]  rid = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ysyx_25040109_lsu #(.AXI_ID(ID)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_sext(req_sext),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rid(rid), .rlast(rlast),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic [1:0]  bresp;
    int          ar_dly, r_dly, aw_dly, w_dly, b_dly;
  } txn_t;

  typedef struct {
    string       name;
    txn_t        t;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_strb;
    int          exp_lat;
    logic        exp_awf;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nresp;
    int          viol;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        aw_first;
    logic        saw_ar;
    logic        saw_aw;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input logic wen, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [1:0] size, input logic sext,
                               input logic [31:0] rd, input logic [1:0] rr, input logic [3:0] ri,
                               input logic [1:0] br, input int ard, input int rdl, input int awd,
                               input int wdl, input int bd, input logic [31:0] er, input logic ee,
                               input logic [3:0] es, input int el, input logic eawf);
    vec_t v;
    v.name = nm;
    v.t.wen = wen; v.t.addr = addr; v.t.wdata = wd; v.t.size = size; v.t.sext = sext;
    v.t.rdata = rd; v.t.rresp = rr; v.t.rid = ri; v.t.bresp = br;
    v.t.ar_dly = ard; v.t.r_dly = rdl; v.t.aw_dly = awd; v.t.w_dly = wdl; v.t.b_dly = bd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_strb = es; v.exp_lat = el; v.exp_awf = eawf;
    return v;
  endfunction

  // Reference behaviour from the access rules: byte lanes, alignment, latency arithmetic.
  task automatic model(input txn_t t, output logic [31:0] er, output logic ee,
                       output logic [3:0] es, output int el);
    int          off, nbytes;
    bit          mis;
    logic [31:0] mask, lane, v;
    off    = int'(t.addr % 4);
    nbytes = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
    mis    = 1'b0;
`ifdef YSYX_25040109_LSU_MISALIGN_CHECK_EN
    mis = ((off % nbytes) != 0);
`endif
    mask = ((32'd1 << nbytes) - 32'd1) << off;
    es   = mask[3:0];
    if (mis) el = 1;
    else if (t.wen) el = 3 + ((t.aw_dly > t.w_dly) ? t.aw_dly : t.w_dly) + t.b_dly;
    else el = 3 + t.ar_dly + t.r_dly;
    ee = mis || (t.wen ? (t.bresp != 2'b00) : ((t.rresp != 2'b00) || (t.rid != ID)));
    lane = t.rdata >> (8 * off);
    if (nbytes == 1) begin
      v = lane % 256;
      if (t.sext && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (nbytes == 2) begin
      v = lane % 65536;
      if (t.sext && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = lane;
    end
    er = (ee || t.wen) ? 32'h0 : v;
  endtask

  // Issues one request and plays the AXI slave until the response plus two idle cycles.
  task automatic run_txn(input txn_t t, output obs_t o);
    bit          ar_ok = 0, r_ok = 0, aw_ok = 0, w_ok = 0, b_ok = 0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    bit          p_arv = 0, p_arr = 0, p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    logic [3:0]  p_wstrb = '0;
    o = '{default: 0};
    @(negedge clk);
    req_valid = 1'b1; req_wen = t.wen; req_addr = t.addr; req_wdata = t.wdata;
    req_size = t.size; req_sext = t.sext;
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 1; cyc <= CYC_MAX; cyc++) begin
      if (resp_valid) begin
        o.nresp++;
        if (o.nresp == 1) begin
          o.rdata = resp_rdata; o.err = resp_err; o.lat = cyc;
        end
      end
      if (o.nresp > 0 && cyc > o.lat + 2) break;
      if (o.nresp == 0 && req_ready) o.viol++;
      if (arvalid) begin
        o.saw_ar = 1'b1;
        if (araddr !== t.addr || arid !== ID) o.viol++;
      end
      if (awvalid) begin
        o.saw_aw = 1'b1;
        if (awaddr !== t.addr) o.viol++;
      end
      if (wvalid) begin
        o.strb = wstrb; o.wdata = wdata;
      end
      if (!awvalid && wvalid) o.aw_first = 1'b1;
      if (p_arv && !p_arr && (!arvalid || araddr !== p_araddr)) o.viol++;
      if (p_awv && !p_awr && (!awvalid || awaddr !== p_awaddr)) o.viol++;
      if (p_wv && !p_wr && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) o.viol++;
      arready = arvalid && (ar_cnt >= t.ar_dly);
      rvalid  = ar_ok && !r_ok && (r_cnt >= t.r_dly);
      rdata   = rvalid ? t.rdata : 32'h0;
      rresp   = rvalid ? t.rresp : 2'b00;
      rid     = rvalid ? t.rid : 4'h0;
      rlast   = rvalid;
      awready = awvalid && (aw_cnt >= t.aw_dly);
      wready  = wvalid && (w_cnt >= t.w_dly);
      bvalid  = aw_ok && w_ok && !b_ok && (b_cnt >= t.b_dly);
      bresp   = bvalid ? t.bresp : 2'b00;
      p_arv = arvalid; p_arr = arready; p_araddr = araddr;
      p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
      p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
      if (ar_ok && !r_ok) begin
        if (rvalid && rready) r_ok = 1; else r_cnt++;
      end
      if (aw_ok && w_ok && !b_ok) begin
        if (bvalid && bready) b_ok = 1; else b_cnt++;
      end
      if (arvalid) begin
        if (arready) ar_ok = 1; else ar_cnt++;
      end
      if (awvalid) begin
        if (awready) aw_ok = 1; else aw_cnt++;
      end
      if (wvalid) begin
        if (wready) w_ok = 1; else w_cnt++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    rdata = '0; rresp = '0; rid = '0; bresp = '0;
  endtask

  task automatic check_obs(input string nm, input txn_t t, input obs_t o, input logic [31:0] er,
                           input logic ee, input logic [3:0] es, input int el);
    chk({nm, "/resp_count"}, 32'(o.nresp), 32'd1);
    chk({nm, "/rdata"}, o.rdata, er);
    chk({nm, "/err"}, 32'(o.err), 32'(ee));
    chk({nm, "/latency"}, 32'(o.lat), 32'(el));
    chk({nm, "/protocol"}, 32'(o.viol), 32'd0);
    chk({nm, "/ar_traffic"}, 32'(o.saw_ar), 32'(el > 1 && !t.wen));
    chk({nm, "/aw_traffic"}, 32'(o.saw_aw), 32'(el > 1 && t.wen));
    if (t.wen && el > 1) begin
      chk({nm, "/wstrb"}, 32'(o.strb), 32'(es));
      chk({nm, "/wdata"}, o.wdata, t.wdata);
    end
  endtask

  initial begin
    vec_t        vecs[$];
    obs_t        o;
    txn_t        t;
    logic [31:0] er;
    logic        ee;
    logic [3:0]  es;
    int          el, stray;

    //              name            wen addr          wdata         sz    sx   rdata         rr     rid   br     ar r aw w b   exp_rdata     err  strb     lat awf
    vecs.push_back(mkv("rd_word",      0, 32'h8000_0004, 32'h0,        2'd2, 0, 32'hDEAD_BEEF, 2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 4'b0000, 3, 0));
    vecs.push_back(mkv("rd_byte_sext", 0, 32'h8000_0003, 32'h0,        2'd0, 1, 32'h8011_2233, 2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 0, 4'b0000, 3, 0));
    vecs.push_back(mkv("rd_byte_zext", 0, 32'h8000_0003, 32'h0,        2'd0, 0, 32'h8011_2233, 2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'h0000_0080, 0, 4'b0000, 3, 0));
    vecs.push_back(mkv("rd_rresp_err", 0, 32'h8000_0000, 32'h0,        2'd2, 0, 32'h1234_5678, 2'b10, ID,   2'b00, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 3, 0));
    vecs.push_back(mkv("rd_rid_err",   0, 32'h8000_0000, 32'h0,        2'd2, 0, 32'h1234_5678, 2'b00, 4'h3, 2'b00, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 3, 0));
    vecs.push_back(mkv("wr_half_awf",  1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 0, 32'h0,       2'b00, ID,   2'b00, 0, 0, 0, 2, 1, 32'h0,         0, 4'b1100, 6, 1));
    vecs.push_back(mkv("rd_ar_stall",  0, 32'h8000_0010, 32'h0,        2'd2, 0, 32'h1234_5678, 2'b00, ID,   2'b00, 10, 0, 0, 0, 0, 32'h1234_5678, 0, 4'b0000, 13, 0));
    vecs.push_back(mkv("rd_half_sext", 0, 32'h8000_0002, 32'h0,        2'd1, 1, 32'h8001_7FFF, 2'b00, ID,   2'b00, 0, 2, 0, 0, 0, 32'hFFFF_8001, 0, 4'b0000, 5, 0));
    vecs.push_back(mkv("rd_size3",     0, 32'h8000_0008, 32'h0,        2'd3, 1, 32'hCAFE_F00D, 2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'hCAFE_F00D, 0, 4'b0000, 3, 0));
    vecs.push_back(mkv("wr_word_same", 1, 32'h8000_000C, 32'h1122_3344, 2'd2, 0, 32'h0,       2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'h0,         0, 4'b1111, 3, 0));
    vecs.push_back(mkv("wr_byte_berr", 1, 32'h8000_0001, 32'h0000_00A5, 2'd0, 0, 32'h0,       2'b00, ID,   2'b11, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0010, 3, 0));
    vecs.push_back(mkv("wr_w_first",   1, 32'h8000_0003, 32'h0000_005A, 2'd0, 0, 32'h0,       2'b00, ID,   2'b00, 0, 0, 3, 0, 0, 32'h0,         0, 4'b1000, 6, 0));
`ifdef YSYX_25040109_LSU_MISALIGN_CHECK_EN
    vecs.push_back(mkv("rd_word_mis",  0, 32'h8000_0001, 32'h0,        2'd2, 0, 32'hAABB_CCDD, 2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 1, 0));
    vecs.push_back(mkv("wr_half_mis",  1, 32'h8000_0003, 32'h0000_1234, 2'd1, 0, 32'h0,       2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'h0,         1, 4'b1000, 1, 0));
`else
    vecs.push_back(mkv("rd_half_mis",  0, 32'h8000_0001, 32'h0,        2'd1, 1, 32'hAABB_CCDD, 2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'hFFFF_BBCC, 0, 4'b0000, 3, 0));
    vecs.push_back(mkv("wr_half_mis",  1, 32'h8000_0003, 32'h0000_1234, 2'd1, 0, 32'h0,       2'b00, ID,   2'b00, 0, 0, 0, 0, 0, 32'h0,         0, 4'b1000, 3, 0));
`endif

    // Reset: outputs quiet and req_ready low while held, ready afterwards.
    req_valid = 1'b1;
    #1;
    chk("reset/ctrl_outputs", 32'({req_ready, arvalid, awvalid, wvalid, rready, bready, resp_valid, resp_err}), 32'd0);
    chk("reset/resp_rdata", resp_rdata, 32'h0);
    repeat (3) @(negedge clk);
    chk("reset/held_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("reset/ready_after", 32'(req_ready), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i].t, o);
      check_obs(vecs[i].name, vecs[i].t, o, vecs[i].exp_rdata, vecs[i].exp_err,
                vecs[i].exp_strb, vecs[i].exp_lat);
      chk({vecs[i].name, "/aw_first"}, 32'(o.aw_first), 32'(vecs[i].exp_awf));
    end

    // Reset while waiting in B: bready drops at once and no response ever appears.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h8000_0020; req_wdata = 32'h5555_AAAA;
    req_size = 2'd2; req_sext = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    chk("rst_in_b/bready_before", 32'(bready), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_in_b/bready_now", 32'(bready), 32'd0);
    chk("rst_in_b/quiet", 32'({req_ready, resp_valid, resp_err, awvalid, wvalid}), 32'd0);
    bvalid = 1'b1;
    stray = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    rst = 1'b0;
    bvalid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) stray++;
    end
    chk("rst_in_b/no_response", 32'(stray), 32'd0);
    chk("rst_in_b/ready_after", 32'(req_ready), 32'd1);

    // Random traffic against the reference model.
    for (int n = 0; n < 150; n++) begin
      t.wen    = 1'($urandom_range(0, 1));
      t.addr   = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      t.wdata  = $urandom;
      t.size   = 2'($urandom_range(0, 3));
      t.sext   = 1'($urandom_range(0, 1));
      t.rdata  = $urandom;
      t.rresp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t.rid    = ($urandom_range(0, 7) == 0) ? 4'h3 : ID;
      t.bresp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      t.ar_dly = int'($urandom_range(0, 3));
      t.r_dly  = int'($urandom_range(0, 3));
      t.aw_dly = int'($urandom_range(0, 3));
      t.w_dly  = int'($urandom_range(0, 3));
      t.b_dly  = int'($urandom_range(0, 3));
      model(t, er, ee, es, el);
      run_txn(t, o);
      check_obs($sformatf("rand%0d", n), t, o, er, ee, es, el);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
